alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream controller for the ALU execution units (arith, logic, compare, shift).
//  - Accepts one command {A, B, ALU_FUN} per valid/ready handshake.
//  - Decodes ALU_FUN[3:2] to exactly one unit enable and drives ALU_FUN[1:0] as that unit's sub-function.
//  - Captures the unit's result on its FLAG and returns it on a valid/ready output port.
//  - Guarantees each unit sees a one-cycle EN pulse with stable operands.
// PARAMETERS
//  IN_DATA_WD  16                 operand width
//  RES_WD      2*IN_DATA_WD       result width; narrower unit results are zero-extended
//  TIMEOUT     8                  max WAIT cycles for a unit FLAG before the error response
// PORTS
//  CLK         in   1            clock, rising edge
//  RST         in   1            reset; synchronous, active-low
//  IN_A        in   IN_DATA_WD   operand A
//  IN_B        in   IN_DATA_WD   operand B
//  IN_FUN      in   4            [3:2] unit: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] sub-function
//  IN_VALID    in   1            command valid
//  IN_READY    out  1            command accepted when IN_VALID & IN_READY
//  A, B        out  IN_DATA_WD   registered operands to all units
//  ALU_FUN     out  2            registered sub-function to all units
//  ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN   out  1 each   unit enables, one-hot or all zero
//  ARITH_OUT   in   RES_WD       arith result
//  LOGIC_OUT, CMP_OUT, SHIFT_OUT   in   IN_DATA_WD each   unit results
//  ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG   in   1 each   result-valid flags
//  RESULT      out  RES_WD       captured result
//  RES_ERR     out  1            1 = unit timed out; RESULT is 0
//  OUT_VALID   out  1            result valid; held until OUT_READY
//  OUT_READY   in   1            downstream accept
// BEHAVIOUR
//  Reset (RST==0 at the clock edge):
//  - State IDLE.
//  - All outputs 0, except IN_READY=1.
//  - Counter cleared.
//  - Applies mid-operation: an in-flight command is dropped, and no EN pulse is issued in the cycle after reset.
//  FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE:
//  - IN_READY=1.
//  - On IN_VALID: register IN_A, IN_B, and IN_FUN into A, B, ALU_FUN and the unit select, then go to ISSUE.
//  ISSUE:
//  - The selected *_EN is high for exactly this one cycle. Go to WAIT and clear the counter.
//  WAIT:
//  - All EN low.
//  - If the selected unit's FLAG=1: RESULT <= its output, zero-extended to RES_WD; RES_ERR <= 0; go to DONE.
//  - Else the counter increments. When the counter reaches TIMEOUT-1 without a flag: RESULT <= 0, RES_ERR <= 1, go to DONE.
//  - Flags from non-selected units are ignored in all states.
//  DONE:
//  - OUT_VALID=1; RESULT and RES_ERR are stable.
//  - On OUT_READY go to IDLE. The next command is accepted no earlier than the following cycle.
//  General rules:
//  - IN_READY=1 only in IDLE. A, B, and ALU_FUN hold from the accept edge until the next accept.
//  - Latency: accept at edge k -> EN high in cycle k+1 -> FLAG in cycle k+2 -> OUT_VALID in cycle k+3. Throughput is 1 command per 4 cycles with OUT_READY tied high.
//  - FLAG and EN in the same cycle (only possible from a stale flag in ISSUE) is ignored; capture happens only in WAIT.
//  - The counter saturates and does not wrap. It is sized $clog2(TIMEOUT+1).
// STRUCTURE
//  Shared package alu_pkg:
//  - Unit-select localparams UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11.
//  - State encoding ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE (2 bits).
//  Sub-module alu_unit_decoder (combinational):
//  - Maps unit select plus an issue strobe to the four EN lines.
//  - Muxes the selected FLAG/OUT back to the controller.
//  The FSM, operand registers, and timeout counter stay in the top level.
// TESTING
//  - Reset: hold RST=0 two cycles with IN_VALID=1 -> all EN=0, OUT_VALID=0, IN_READY=1.
//  - Shift: A=16'h8001, IN_FUN=4'b1101, SHIFT unit model attached -> SHIFT_EN pulses 1 cycle; RESULT=32'h0000_0002, OUT_VALID at accept+3.
//  - Backpressure: OUT_READY=0 for 5 cycles -> OUT_VALID/RESULT held and IN_READY=0 throughout; release -> IDLE next cycle.
//  - Timeout: IN_FUN=4'b0100, LOGIC_FLAG tied 0 -> RES_ERR=1, RESULT=0, OUT_VALID after TIMEOUT WAIT cycles.
//  - Cross-flag: select CMP, pulse SHIFT_FLAG=1 with SHIFT_OUT=16'hFFFF during WAIT, then CMP_FLAG with CMP_OUT=1 -> RESULT=1.
//  - Reset mid-op: RST=0 in ISSUE cycle -> no EN pulse next cycle; state IDLE; the old command is never returned.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: unit selects and controller states.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_unit_decoder.sv
// Turns a unit select plus issue strobe into one-hot enables and returns the
// selected unit's flag and zero-extended result.
module alu_unit_decoder
  import alu_pkg::*;
#(
  parameter int IN_DATA_WD = 16,
  parameter int RES_WD     = 2 * IN_DATA_WD
) (
  input  logic [1:0]            unit_sel,
  input  logic                  issue,
  input  logic                  arith_flag,
  input  logic                  logic_flag,
  input  logic                  cmp_flag,
  input  logic                  shift_flag,
  input  logic [RES_WD-1:0]     arith_out,
  input  logic [IN_DATA_WD-1:0] logic_out,
  input  logic [IN_DATA_WD-1:0] cmp_out,
  input  logic [IN_DATA_WD-1:0] shift_out,
  output logic                  arith_en,
  output logic                  logic_en,
  output logic                  cmp_en,
  output logic                  shift_en,
  output logic                  sel_flag,
  output logic [RES_WD-1:0]     sel_out
);

  always_comb begin
    arith_en = 1'b0;
    logic_en = 1'b0;
    cmp_en   = 1'b0;
    shift_en = 1'b0;
    sel_flag = 1'b0;
    sel_out  = '0;
    case (unit_sel)
      UNIT_ARITH: begin
        arith_en = issue;
        sel_flag = arith_flag;
        sel_out  = arith_out;
      end
      UNIT_LOGIC: begin
        logic_en = issue;
        sel_flag = logic_flag;
        sel_out  = RES_WD'(logic_out);
      end
      UNIT_CMP: begin
        cmp_en   = issue;
        sel_flag = cmp_flag;
        sel_out  = RES_WD'(cmp_out);
      end
      UNIT_SHIFT: begin
        shift_en = issue;
        sel_flag = shift_flag;
        sel_out  = RES_WD'(shift_out);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the ALU units: accepts a command, pulses one unit enable,
// waits (bounded) for that unit's flag and returns the captured result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int IN_DATA_WD = 16,
  parameter int RES_WD     = 2 * IN_DATA_WD,
  parameter int TIMEOUT    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN_DATA_WD-1:0] IN_A,
  input  logic [IN_DATA_WD-1:0] IN_B,
  input  logic [3:0]            IN_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [IN_DATA_WD-1:0] A,
  output logic [IN_DATA_WD-1:0] B,
  output logic [1:0]            ALU_FUN,
  output logic                  ARITH_EN,
  output logic                  LOGIC_EN,
  output logic                  CMP_EN,
  output logic                  SHIFT_EN,
  input  logic [RES_WD-1:0]     ARITH_OUT,
  input  logic [IN_DATA_WD-1:0] LOGIC_OUT,
  input  logic [IN_DATA_WD-1:0] CMP_OUT,
  input  logic [IN_DATA_WD-1:0] SHIFT_OUT,
  input  logic                  ARITH_FLAG,
  input  logic                  LOGIC_FLAG,
  input  logic                  CMP_FLAG,
  input  logic                  SHIFT_FLAG,
  output logic [RES_WD-1:0]     RESULT,
  output logic                  RES_ERR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int                CNT_WD   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [1:0]          unit_sel_q;
  logic [CNT_WD-1:0]   cnt_q;
  logic                accept, capture, timeout, cnt_clr, cnt_inc;
  logic                sel_flag;
  logic [RES_WD-1:0]   sel_out;

  alu_unit_decoder #(
    .IN_DATA_WD (IN_DATA_WD),
    .RES_WD     (RES_WD)
  ) u_decoder (
    .unit_sel   (unit_sel_q),
    .issue      (state_q == ST_ISSUE),
    .arith_flag (ARITH_FLAG),
    .logic_flag (LOGIC_FLAG),
    .cmp_flag   (CMP_FLAG),
    .shift_flag (SHIFT_FLAG),
    .arith_out  (ARITH_OUT),
    .logic_out  (LOGIC_OUT),
    .cmp_out    (CMP_OUT),
    .shift_out  (SHIFT_OUT),
    .arith_en   (ARITH_EN),
    .logic_en   (LOGIC_EN),
    .cmp_en     (CMP_EN),
    .shift_en   (SHIFT_EN),
    .sel_flag   (sel_flag),
    .sel_out    (sel_out)
  );

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A flag on the final allowed cycle still wins over the timeout.
        if (sel_flag) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      unit_sel_q <= '0;
      A          <= '0;
      B          <= '0;
      ALU_FUN    <= '0;
      cnt_q      <= '0;
      RESULT     <= '0;
      RES_ERR    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        A          <= IN_A;
        B          <= IN_B;
        ALU_FUN    <= IN_FUN[1:0];
        unit_sel_q <= IN_FUN[3:2];
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_WD'(1);
      if (capture) begin
        RESULT  <= sel_out;
        RES_ERR <= 1'b0;
      end else if (timeout) begin
        RESULT  <= '0;
        RES_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with behavioural unit models and a
// result scoreboard drained by an independent output monitor.
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IN_A, IN_B;
  logic [3:0]  IN_FUN;
  logic        IN_VALID, IN_READY;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
  logic [31:0] ARITH_OUT;
  logic [15:0] LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
  logic [31:0] RESULT;
  logic        RES_ERR, OUT_VALID, OUT_READY;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  auto_en = 4'b1111;   // index 0 arith, 1 logic, 2 cmp, 3 shift
  logic [3:0]  a_flag = '0;
  logic [31:0] a_out[4];
  logic [3:0]  m_flag = '0;
  logic [15:0] m_out[4];
  logic [3:0]  en_v;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(
    .IN_DATA_WD (16),
    .RES_WD     (32),
    .TIMEOUT    (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_A       (IN_A),
    .IN_B       (IN_B),
    .IN_FUN     (IN_FUN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ARITH_EN   (ARITH_EN),
    .LOGIC_EN   (LOGIC_EN),
    .CMP_EN     (CMP_EN),
    .SHIFT_EN   (SHIFT_EN),
    .ARITH_OUT  (ARITH_OUT),
    .LOGIC_OUT  (LOGIC_OUT),
    .CMP_OUT    (CMP_OUT),
    .SHIFT_OUT  (SHIFT_OUT),
    .ARITH_FLAG (ARITH_FLAG),
    .LOGIC_FLAG (LOGIC_FLAG),
    .CMP_FLAG   (CMP_FLAG),
    .SHIFT_FLAG (SHIFT_FLAG),
    .RESULT     (RESULT),
    .RES_ERR    (RES_ERR),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
  );

  assign en_v = {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN};

  function automatic logic [31:0] unit_calc(input int u, input logic [1:0] f,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    r = '0;
    case (u)
      0: case (f)
           2'd0: r = {16'h0, a} + {16'h0, b};
           2'd1: r = {16'h0, a} * {16'h0, b};
           2'd2: r = {16'h0, a} - {16'h0, b};
           default: r = {16'h0, a};
         endcase
      1: case (f)
           2'd0: r = {16'h0, a & b};
           2'd1: r = {16'h0, a | b};
           2'd2: r = {16'h0, a ^ b};
           default: r = {16'h0, ~a};
         endcase
      2: case (f)
           2'd0: r = {31'h0, a == b};
           2'd1: r = {31'h0, a < b};
           2'd2: r = {31'h0, a > b};
           default: r = {31'h0, a != b};
         endcase
      default: case (f)
           2'd0: r = {16'h0, a >> b[3:0]};
           2'd1: r = {16'h0, a << b[3:0]};
           default: r = {16'h0, a};
         endcase
    endcase
    return r;
  endfunction

  // Unit models: flag and result one cycle after their enable.
  always @(posedge CLK) begin
    a_flag <= {SHIFT_EN & auto_en[3], CMP_EN & auto_en[2], LOGIC_EN & auto_en[1], ARITH_EN & auto_en[0]};
    for (int u = 0; u < 4; u++) a_out[u] <= unit_calc(u, ALU_FUN, A, B);
  end

  assign ARITH_FLAG = a_flag[0] | m_flag[0];
  assign LOGIC_FLAG = a_flag[1] | m_flag[1];
  assign CMP_FLAG   = a_flag[2] | m_flag[2];
  assign SHIFT_FLAG = a_flag[3] | m_flag[3];
  assign ARITH_OUT  = a_out[0];
  assign LOGIC_OUT  = m_flag[1] ? m_out[1] : a_out[1][15:0];
  assign CMP_OUT    = m_flag[2] ? m_out[2] : a_out[2][15:0];
  assign SHIFT_OUT  = m_flag[3] ? m_out[3] : a_out[3][15:0];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: samples mid-cycle after stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result %0h err %0b expected no output", RESULT, RES_ERR);
        end else begin
          e = sb.pop_front();
          chk("result", RESULT, e.res);
          chk("res_err", RES_ERR, e.err);
        end
      end
    end
  end

  // Waits for IDLE, issues one command and returns at the negedge of the ISSUE cycle.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                      input logic [31:0] r, input logic e, input bit push);
    int n = 0;
    while (IN_READY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", (n < 40), 1);
    #1;
    IN_A = a; IN_B = b; IN_FUN = f; IN_VALID = 1'b1;
    if (push) sb.push_back('{res: r, err: e});
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  // From the ISSUE negedge, counts cycles to OUT_VALID and cycles with any enable high.
  task automatic wait_done(output int lat, output int ens);
    lat = 1;
    ens = (|en_v) ? 1 : 0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (|en_v) ens++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [31:0] r;
  } vec_t;

  initial begin
    int lat, ens, ov;
    vec_t vecs[3];
    vecs[0] = '{a: 16'h1234, b: 16'h0100, f: 4'b0001, r: 32'h0012_3400};
    vecs[1] = '{a: 16'hF0F0, b: 16'hFF00, f: 4'b0110, r: 32'h0000_0FF0};
    vecs[2] = '{a: 16'h0003, b: 16'h0005, f: 4'b1001, r: 32'h0000_0001};

    RST = 1'b0; IN_A = 16'h5555; IN_B = 16'hAAAA; IN_FUN = 4'b1101;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (int u = 0; u < 4; u++) m_out[u] = '0;

    repeat (2) @(negedge CLK);
    chk("rst_en", en_v, 4'b0000);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_result", {RES_ERR, RESULT}, 0);
    chk("rst_a", A, 0);
    #1 RST = 1'b1; IN_VALID = 1'b0;

    // Shift left by one: 8001 -> 0002, single SHIFT_EN pulse, 3-cycle latency
    @(negedge CLK);
    send(16'h8001, 16'h0001, 4'b1101, 32'h0000_0002, 1'b0, 1);
    chk("shift_en", en_v, 4'b0001);
    chk("shift_in_ready", IN_READY, 0);
    chk("shift_ops", {A, ALU_FUN}, {16'h8001, 2'b01});
    wait_done(lat, ens);
    chk("shift_latency", lat, 3);
    chk("shift_en_cycles", ens, 1);

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].r, 1'b0, 1);
      wait_done(lat, ens);
      chk("vec_latency", lat, 3);
    end

    // Backpressure
    @(negedge CLK);
    #1 OUT_READY = 1'b0;
    send(16'h1234, 16'h0F0F, 4'b0000, 32'h0000_2143, 1'b0, 1);
    chk("bp_en", en_v, 4'b1000);
    wait_done(lat, ens);
    chk("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", OUT_VALID, 1);
      chk("bp_result", RESULT, 32'h0000_2143);
      chk("bp_in_ready", IN_READY, 0);
      @(negedge CLK);
    end
    #1 OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_idle", {IN_READY, OUT_VALID}, 2'b10);

    // Timeout: logic unit never answers
    #1 auto_en[1] = 1'b0;
    send(16'hABCD, 16'h1234, 4'b0100, 32'h0, 1'b1, 1);
    wait_done(lat, ens);
    chk("timeout_latency", lat, 10);
    chk("timeout_en_cycles", ens, 1);
    @(negedge CLK);
    #1 auto_en[1] = 1'b1; auto_en[2] = 1'b0;

    // Cross-flag: stale CMP flag in ISSUE and a SHIFT flag in WAIT are ignored
    send(16'h0005, 16'h0007, 4'b1000, 32'h0000_0001, 1'b0, 1);
    chk("cmp_en", en_v, 4'b0010);
    #1 m_flag[2] = 1'b1; m_out[2] = 16'h00AA;
    @(negedge CLK);
    chk("xf_wait1", OUT_VALID, 0);
    #1 m_flag[2] = 1'b0; m_flag[3] = 1'b1; m_out[3] = 16'hFFFF;
    @(negedge CLK);
    chk("xf_wait2", OUT_VALID, 0);
    #1 m_flag[3] = 1'b0;
    @(negedge CLK);
    #1 m_flag[2] = 1'b1; m_out[2] = 16'h0001;
    @(negedge CLK);
    chk("xf_done", OUT_VALID, 1);
    #1 m_flag[2] = 1'b0; auto_en[2] = 1'b1;
    @(negedge CLK);

    // Reset during ISSUE drops the command
    send(16'h0001, 16'h0001, 4'b0000, 32'h0, 1'b0, 0);
    chk("mid_en", en_v, 4'b1000);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_en", en_v, 4'b0000);
    chk("mid_rst_state", {IN_READY, OUT_VALID}, 2'b10);
    #1 RST = 1'b1;
    ov = 0;
    repeat (12) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) ov++;
    end
    chk("mid_no_output", ov, 0);

    // Recovery after the dropped command
    send(16'h00FF, 16'h0F0F, 4'b0101, 32'h0000_0FFF, 1'b0, 1);
    wait_done(lat, ens);
    chk("recover_latency", lat, 3);
    repeat (2) @(negedge CLK);
    #3;
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
